// File: rtl/pwm_ciclo_multicanal_if.sv
// Command/status bundle of the multi-channel PWM generator: duty up/down requests
// and channel select in, PWM outputs and the selected channel's shadow duty out.
interface pwm_ciclo_multicanal_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic                up;
    logic                down;
    logic                chip_select;
    logic [SEL_W-1:0]    sel;
    logic [CHANNELS-1:0] signal_out;
    logic [WIDTH-1:0]    ciclo_actual;
    logic                period_start;

    modport master (
        output up, down, chip_select, sel,
        input  signal_out, ciclo_actual, period_start
    );

    modport slave (
        input  up, down, chip_select, sel,
        output signal_out, ciclo_actual, period_start
    );
endinterface

// File: rtl/pwm_ciclo_multicanal.sv
// Multi-channel PWM with a shared prescaled reference counter; per-channel duties
// are adjusted by edge-detected up/down commands into shadow registers.
module pwm_ciclo_multicanal #(
    parameter int WIDTH     = 4,
    parameter int CHANNELS  = 4,
    parameter int SEL_W     = 2,
    parameter int PRESCALE  = 100,
    parameter int STEP      = 1,
    parameter int DUTY_INIT = 8
) (
    input logic                   clk_100MHz,
    input logic                   rst,
    pwm_ciclo_multicanal_if.slave bus
);
    localparam int              PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] DUTY_MAX = '1;
    localparam logic [WIDTH-1:0] DUTY_RST = WIDTH'(DUTY_INIT);
    localparam logic [WIDTH:0]   STEP_W   = (WIDTH+1)'(STEP);

    typedef enum logic [1:0] {CMD_NONE, CMD_UP, CMD_DOWN} cmd_e;

    logic [PS_W-1:0]  ps_cnt;
    logic [WIDTH-1:0] ref_cnt;
    logic [WIDTH-1:0] shadow [CHANNELS];
    logic [WIDTH-1:0] active [CHANNELS];
    logic             up_q;
    logic             down_q;
    logic             tick;
    logic             boundary;
    logic             sel_valid;
    cmd_e             cmd;
    logic [WIDTH-1:0] sel_duty;
    logic [WIDTH-1:0] next_duty;
    logic [WIDTH:0]   sum;

    assign tick      = (ps_cnt == PS_W'(PRESCALE - 1));
    assign boundary  = tick && (ref_cnt == DUTY_MAX);
    assign sel_valid = (32'(bus.sel) < CHANNELS);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        sel_duty = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.sel == SEL_W'(i)) sel_duty = shadow[i];
        end
    end

    // Simultaneous up and down rises cancel each other.
    always_comb begin
        cmd = CMD_NONE;
        if (bus.chip_select && sel_valid) begin
            case ({bus.up & ~up_q, bus.down & ~down_q})
                2'b10:   cmd = CMD_UP;
                2'b01:   cmd = CMD_DOWN;
                default: cmd = CMD_NONE;
            endcase
        end
    end

    always_comb begin
        sum       = {1'b0, sel_duty} + STEP_W;
        next_duty = sel_duty;
        case (cmd)
            CMD_UP:   next_duty = (sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : sum[WIDTH-1:0];
            CMD_DOWN: next_duty = ({1'b0, sel_duty} < STEP_W) ? '0 : sel_duty - STEP_W[WIDTH-1:0];
            default:  next_duty = sel_duty;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            ps_cnt  <= '0;
            ref_cnt <= '0;
            // Held-high buttons must not look like a fresh press once reset lifts.
            up_q    <= 1'b1;
            down_q  <= 1'b1;
            // NOTE: the duty arrays are state with a defined power-up value, so they are reset like any flop.
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= DUTY_RST;
                active[i] <= DUTY_RST;
            end
            bus.signal_out   <= '0;
            bus.ciclo_actual <= DUTY_RST;
            bus.period_start <= 1'b0;
        end else begin
            // NOTE: non-blocking updates mean active[] takes the pre-edge shadow, so a write on the boundary edge waits one period.
            ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
            if (tick) ref_cnt <= ref_cnt + 1'b1;
            up_q   <= bus.up;
            down_q <= bus.down;
            for (int i = 0; i < CHANNELS; i++) begin
                if (cmd != CMD_NONE && bus.sel == SEL_W'(i)) shadow[i] <= next_duty;
                if (boundary) active[i] <= shadow[i];
                bus.signal_out[i] <= (ref_cnt < active[i]);
            end
            bus.ciclo_actual <= sel_valid ? sel_duty : '0;
            bus.period_start <= boundary;
        end
    end
endmodule

// File: tb/tb_pwm_ciclo_multicanal.sv
// Directed bench for pwm_ciclo_multicanal: a 4-channel instance for the main
// behaviour and a 3-channel instance for the out-of-range select case.
module tb_pwm_ciclo_multicanal;
    localparam int WIDTH      = 4;
    localparam int CH         = 4;
    localparam int SEL_W      = 2;
    localparam int PRESCALE   = 2;
    localparam int STEP       = 1;
    localparam int DUTY_INIT  = 8;
    localparam int PERIOD_CLK = 16 * PRESCALE;

    logic clk_100MHz = 1'b0;
    logic rst;
    always #5 clk_100MHz = ~clk_100MHz;

    pwm_ciclo_multicanal_if #(.WIDTH(WIDTH), .CHANNELS(CH), .SEL_W(SEL_W)) bus4 ();
    pwm_ciclo_multicanal_if #(.WIDTH(WIDTH), .CHANNELS(3),  .SEL_W(SEL_W)) bus3 ();

    pwm_ciclo_multicanal #(
        .WIDTH(WIDTH), .CHANNELS(CH), .SEL_W(SEL_W),
        .PRESCALE(PRESCALE), .STEP(STEP), .DUTY_INIT(DUTY_INIT)
    ) u_dut (
        .clk_100MHz(clk_100MHz),
        .rst(rst),
        .bus(bus4)
    );

    pwm_ciclo_multicanal #(
        .WIDTH(WIDTH), .CHANNELS(3), .SEL_W(SEL_W),
        .PRESCALE(PRESCALE), .STEP(STEP), .DUTY_INIT(DUTY_INIT)
    ) u_dut3 (
        .clk_100MHz(clk_100MHz),
        .rst(rst),
        .bus(bus3)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int hi_cnt [CH];

    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        step();
    endtask

    task automatic pulse(input logic is_up, input logic is_down);
        bus4.up   = is_up;
        bus4.down = is_down;
        step();
        bus4.up   = 1'b0;
        bus4.down = 1'b0;
        step();
    endtask

    // Advances until period_start is seen; cycles is the number of edges taken.
    task automatic wait_ps(output logic ok, output int cycles);
        ok     = 1'b0;
        cycles = 0;
        for (int i = 0; i < 4 * PERIOD_CLK; i++) begin
            step();
            cycles++;
            if (bus4.period_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_period();
        for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
        for (int k = 0; k < PERIOD_CLK; k++) begin
            step();
            for (int c = 0; c < CH; c++) if (bus4.signal_out[c]) hi_cnt[c]++;
        end
    endtask

    task automatic expect_ps();
        logic ok;
        int   cyc;
        wait_ps(ok, cyc);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL wait_period_start: no pulse within %0d cycles, required one", cyc);
        end
    endtask

    task automatic test_reset();
        logic ok;
        int   cyc;
        tests_run++;
        if (bus4.signal_out !== 4'h0 || bus4.ciclo_actual !== 4'd8 || bus4.period_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: out=%h ciclo=%0d ps=%b, required 0/8/0",
                     bus4.signal_out, bus4.ciclo_actual, bus4.period_start);
        end
        rst = 1'b0;
        step();
        step();
        step();
        tests_run++;
        if (bus4.signal_out !== 4'hF) begin
            tests_failed++;
            $display("FAIL early_high: out=%h, required f", bus4.signal_out);
        end
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus4.signal_out !== 4'h0 || bus4.ciclo_actual !== 4'd8 || bus4.period_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: out=%h ciclo=%0d ps=%b, required 0/8/0",
                     bus4.signal_out, bus4.ciclo_actual, bus4.period_start);
        end
        @(posedge clk_100MHz);
        #1;
        rst = 1'b0;
        wait_ps(ok, cyc);
        tests_run++;
        if (!ok || cyc != PERIOD_CLK) begin
            tests_failed++;
            $display("FAIL first_period: period_start after %0d cycles, required %0d", cyc, PERIOD_CLK);
        end
        count_period();
        for (int c = 0; c < CH; c++) begin
            tests_run++;
            if (hi_cnt[c] != 16) begin
                tests_failed++;
                $display("FAIL half_duty_ch%0d: high %0d clk, required 16", c, hi_cnt[c]);
            end
        end
        tests_run++;
        if (bus4.period_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL period_interval: period_start=%b after %0d clk, required 1", bus4.period_start, PERIOD_CLK);
        end
        step();
        tests_run++;
        if (bus4.period_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL period_pulse_width: period_start=%b, required 0", bus4.period_start);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] exp;
        do_reset();
        bus4.chip_select = 1'b1;
        bus4.sel         = 2'd2;
        step();
        for (int n = 1; n <= 10; n++) begin
            pulse(1'b1, 1'b0);
            exp = 4'((8 + n > 15) ? 15 : 8 + n);
            tests_run++;
            if (bus4.ciclo_actual !== exp) begin
                tests_failed++;
                $display("FAIL up_%0d: ciclo_actual=%0d, required %0d", n, bus4.ciclo_actual, exp);
            end
        end
        expect_ps();
        count_period();
        tests_run++;
        if (hi_cnt[2] != 30 || hi_cnt[0] != 16) begin
            tests_failed++;
            $display("FAIL duty_max: ch2 high %0d ch0 high %0d, required 30 and 16", hi_cnt[2], hi_cnt[0]);
        end
        for (int n = 1; n <= 20; n++) begin
            pulse(1'b0, 1'b1);
            exp = 4'((15 - n < 0) ? 0 : 15 - n);
            tests_run++;
            if (bus4.ciclo_actual !== exp) begin
                tests_failed++;
                $display("FAIL down_%0d: ciclo_actual=%0d, required %0d", n, bus4.ciclo_actual, exp);
            end
        end
        expect_ps();
        count_period();
        tests_run++;
        if (hi_cnt[2] != 0 || hi_cnt[3] != 16) begin
            tests_failed++;
            $display("FAIL duty_zero: ch2 high %0d ch3 high %0d, required 0 and 16", hi_cnt[2], hi_cnt[3]);
        end
    endtask

    task automatic test_mid_period();
        int hi;
        do_reset();
        bus4.chip_select = 1'b1;
        bus4.sel         = 2'd1;
        step();
        expect_ps();
        hi = 0;
        for (int k = 1; k <= PERIOD_CLK; k++) begin
            if (k == 5) bus4.up = 1'b1;
            if (k == 6) bus4.up = 1'b0;
            step();
            if (bus4.signal_out[1]) hi++;
            if (k == 5) begin
                tests_run++;
                if (bus4.ciclo_actual !== 4'd8) begin
                    tests_failed++;
                    $display("FAIL mid_latency_before: ciclo_actual=%0d, required 8", bus4.ciclo_actual);
                end
            end
            if (k == 6) begin
                tests_run++;
                if (bus4.ciclo_actual !== 4'd9) begin
                    tests_failed++;
                    $display("FAIL mid_latency_after: ciclo_actual=%0d, required 9", bus4.ciclo_actual);
                end
            end
        end
        tests_run++;
        if (hi != 16 || bus4.period_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_no_glitch: ch1 high %0d ps=%b, required 16 and 1", hi, bus4.period_start);
        end
        count_period();
        tests_run++;
        if (hi_cnt[1] != 18 || hi_cnt[0] != 16) begin
            tests_failed++;
            $display("FAIL mid_new_duty: ch1 high %0d ch0 high %0d, required 18 and 16", hi_cnt[1], hi_cnt[0]);
        end
        // Place the next write exactly on the boundary edge.
        for (int k = 0; k < PERIOD_CLK - 1; k++) step();
        bus4.up = 1'b1;
        step();
        bus4.up = 1'b0;
        tests_run++;
        if (bus4.period_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL boundary_align: period_start=%b, required 1", bus4.period_start);
        end
        count_period();
        tests_run++;
        if (hi_cnt[1] != 18) begin
            tests_failed++;
            $display("FAIL boundary_write_deferred: ch1 high %0d, required 18", hi_cnt[1]);
        end
        count_period();
        tests_run++;
        if (hi_cnt[1] != 20) begin
            tests_failed++;
            $display("FAIL boundary_write_next: ch1 high %0d, required 20", hi_cnt[1]);
        end
    endtask

    task automatic test_edges();
        do_reset();
        bus4.chip_select = 1'b1;
        bus4.sel         = 2'd3;
        step();
        pulse(1'b1, 1'b1);
        tests_run++;
        if (bus4.ciclo_actual !== 4'd8) begin
            tests_failed++;
            $display("FAIL both_rise: ciclo_actual=%0d, required 8", bus4.ciclo_actual);
        end
        bus4.up = 1'b1;
        repeat (100) step();
        bus4.up = 1'b0;
        step();
        step();
        tests_run++;
        if (bus4.ciclo_actual !== 4'd9) begin
            tests_failed++;
            $display("FAIL held_up: ciclo_actual=%0d, required 9", bus4.ciclo_actual);
        end
        bus4.up = 1'b1;
        rst     = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (10) step();
        tests_run++;
        if (bus4.ciclo_actual !== 4'd8) begin
            tests_failed++;
            $display("FAIL held_through_reset: ciclo_actual=%0d, required 8", bus4.ciclo_actual);
        end
        bus4.up = 1'b0;
        step();
        step();
        tests_run++;
        if (bus4.ciclo_actual !== 4'd8) begin
            tests_failed++;
            $display("FAIL release_after_reset: ciclo_actual=%0d, required 8", bus4.ciclo_actual);
        end
    endtask

    task automatic test_chip_select();
        do_reset();
        bus4.chip_select = 1'b0;
        for (int s = 0; s < CH; s++) begin
            bus4.sel = SEL_W'(s);
            pulse(1'b1, 1'b0);
            pulse(1'b1, 1'b0);
            tests_run++;
            if (bus4.ciclo_actual !== 4'd8) begin
                tests_failed++;
                $display("FAIL cs_off_up_ch%0d: ciclo_actual=%0d, required 8", s, bus4.ciclo_actual);
            end
            pulse(1'b0, 1'b1);
            tests_run++;
            if (bus4.ciclo_actual !== 4'd8) begin
                tests_failed++;
                $display("FAIL cs_off_down_ch%0d: ciclo_actual=%0d, required 8", s, bus4.ciclo_actual);
            end
        end
        bus4.chip_select = 1'b1;
        bus4.sel         = 2'd0;
        step();
        repeat (3) pulse(1'b1, 1'b0);
        tests_run++;
        if (bus4.ciclo_actual !== 4'd11) begin
            tests_failed++;
            $display("FAIL cs_on_ch0: ciclo_actual=%0d, required 11", bus4.ciclo_actual);
        end
        for (int s = 1; s < CH; s++) begin
            bus4.sel = SEL_W'(s);
            step();
            tests_run++;
            if (bus4.ciclo_actual !== 4'd8) begin
                tests_failed++;
                $display("FAIL isolation_ch%0d: ciclo_actual=%0d, required 8", s, bus4.ciclo_actual);
            end
        end
    endtask

    task automatic test_invalid_sel();
        do_reset();
        bus3.chip_select = 1'b1;
        bus3.sel         = 2'd3;
        step();
        tests_run++;
        if (bus3.ciclo_actual !== 4'd0) begin
            tests_failed++;
            $display("FAIL sel_oob_read: ciclo_actual=%0d, required 0", bus3.ciclo_actual);
        end
        bus3.up = 1'b1;
        step();
        bus3.up = 1'b0;
        step();
        tests_run++;
        if (bus3.ciclo_actual !== 4'd0) begin
            tests_failed++;
            $display("FAIL sel_oob_up: ciclo_actual=%0d, required 0", bus3.ciclo_actual);
        end
        for (int s = 0; s < 3; s++) begin
            bus3.sel = SEL_W'(s);
            step();
            tests_run++;
            if (bus3.ciclo_actual !== 4'd8) begin
                tests_failed++;
                $display("FAIL sel_oob_ch%0d: ciclo_actual=%0d, required 8", s, bus3.ciclo_actual);
            end
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus4.up          = 1'b0;
        bus4.down        = 1'b0;
        bus4.chip_select = 1'b0;
        bus4.sel         = '0;
        bus3.up          = 1'b0;
        bus3.down        = 1'b0;
        bus3.chip_select = 1'b0;
        bus3.sel         = '0;
        #1;
        test_reset();
        test_saturation();
        test_mid_period();
        test_edges();
        test_chip_select();
        test_invalid_sel();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
